// File: rtl/alu_acc_n_if.sv
// Operand/control bus between the instruction controller and the accumulator ALU.
// The controller drives the master side; the ALU presents the slave side.
interface alu_acc_n_if #(
   parameter int WIDTH = 8
);
   logic             load;
   logic [WIDTH-1:0] din;
   logic             start;
   logic [1:0]       mode;
   logic [3:0]       s;
   logic             cin_n;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_hi;
   logic             cout_n;
   logic             zero;
   logic             busy;
   logic             done;

   modport master (
      output load, din, start, mode, s, cin_n, b,
      input  acc, acc_hi, cout_n, zero, busy, done
   );

   modport slave (
      input  load, din, start, mode, s, cin_n, b,
      output acc, acc_hi, cout_n, zero, busy, done
   );
endinterface

// File: rtl/alu_acc_n.sv
// Accumulator ALU: full 74181 logic/arithmetic set against acc (A) and b (B),
// registered carry/zero flags, and a WIDTH-cycle unsigned shift-add multiply.
module alu_acc_n #(
   parameter int WIDTH = 8
) (
   input logic        clk,
   input logic        rst_n,
   alu_acc_n_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      MUL
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_hi_q;
   logic             cout_n_q;
   logic             zero_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] p_hi;
   logic [WIDTH-1:0] p_lo;
   logic [CW-1:0]    step;

   logic [WIDTH-1:0] logic_res;
   logic [WIDTH:0]   t_x;
   logic [WIDTH:0]   t_y;
   logic [WIDTH:0]   arith_sum;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_next;
   logic [WIDTH-1:0] mul_lo_next;

   assign bus.acc    = acc_q;
   assign bus.acc_hi = acc_hi_q;
   assign bus.cout_n = cout_n_q;
   assign bus.zero   = zero_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

   always_comb begin
      logic_res = '0;
      case (bus.s)
         4'h0: logic_res = ~acc_q;
         4'h1: logic_res = ~(acc_q | bus.b);
         4'h2: logic_res = ~acc_q & bus.b;
         4'h3: logic_res = '0;
         4'h4: logic_res = ~(acc_q & bus.b);
         4'h5: logic_res = ~bus.b;
         4'h6: logic_res = acc_q ^ bus.b;
         4'h7: logic_res = acc_q & ~bus.b;
         4'h8: logic_res = ~acc_q | bus.b;
         4'h9: logic_res = ~(acc_q ^ bus.b);
         4'hA: logic_res = bus.b;
         4'hB: logic_res = acc_q & bus.b;
         4'hC: logic_res = '1;
         4'hD: logic_res = acc_q | ~bus.b;
         4'hE: logic_res = acc_q | bus.b;
         default: logic_res = acc_q;
      endcase
   end

   // Both terms are zero-extended to WIDTH+1 so bit WIDTH of the sum is the
   // carry; "minus one" is realised by adding WIDTH ones in the low bits.
   always_comb begin
      logic [WIDTH:0] a;
      logic [WIDTH:0] bp;
      logic [WIDTH:0] bn;
      logic [WIDTH:0] ones;
      a    = {1'b0, acc_q};
      bp   = {1'b0, bus.b};
      bn   = {1'b0, ~bus.b};
      ones = {1'b0, {WIDTH{1'b1}}};
      t_x  = '0;
      t_y  = '0;
      case (bus.s)
         4'h0: begin t_x = a;       t_y = '0;     end
         4'h1: begin t_x = a | bp;  t_y = '0;     end
         4'h2: begin t_x = a | bn;  t_y = '0;     end
         4'h3: begin t_x = '0;      t_y = ones;   end
         4'h4: begin t_x = a;       t_y = a & bn; end
         4'h5: begin t_x = a | bp;  t_y = a & bn; end
         4'h6: begin t_x = a;       t_y = bn;     end
         4'h7: begin t_x = a & bn;  t_y = ones;   end
         4'h8: begin t_x = a;       t_y = a & bp; end
         4'h9: begin t_x = a;       t_y = bp;     end
         4'hA: begin t_x = a | bn;  t_y = a & bp; end
         4'hB: begin t_x = a & bp;  t_y = ones;   end
         4'hC: begin t_x = a;       t_y = a;      end
         4'hD: begin t_x = a | bp;  t_y = a;      end
         4'hE: begin t_x = a | bn;  t_y = a;      end
         default: begin t_x = a;    t_y = ones;   end
      endcase
      arith_sum = t_x + t_y + {{WIDTH{1'b0}}, ~bus.cin_n};
   end

   always_comb begin
      mul_sum     = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
      mul_hi_next = mul_sum[WIDTH:1];
      mul_lo_next = {mul_sum[0], p_lo[WIDTH-1:1]};
   end

   // In MUL the product shifts through p_hi/p_lo; acc/acc_hi are only written
   // on the final step so the visible result never shows partial products.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         acc_q    <= '0;
         acc_hi_q <= '0;
         cout_n_q <= 1'b1;
         zero_q   <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         mcand    <= '0;
         p_hi     <= '0;
         p_lo     <= '0;
         step     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.load) begin
                  acc_q  <= bus.din;
                  zero_q <= (bus.din == '0);
               end else if (bus.start) begin
                  case (bus.mode)
                     2'b00: begin
                        acc_q  <= logic_res;
                        zero_q <= (logic_res == '0);
                        done_q <= 1'b1;
                     end
                     2'b01: begin
                        acc_q    <= arith_sum[WIDTH-1:0];
                        cout_n_q <= ~arith_sum[WIDTH];
                        zero_q   <= (arith_sum[WIDTH-1:0] == '0);
                        done_q   <= 1'b1;
                     end
                     2'b10: begin
                        mcand  <= acc_q;
                        p_lo   <= bus.b;
                        p_hi   <= '0;
                        step   <= '0;
                        busy_q <= 1'b1;
                        state  <= MUL;
                     end
                     default: begin
                        done_q <= 1'b1;
                     end
                  endcase
               end
            end
            MUL: begin
               p_hi <= mul_hi_next;
               p_lo <= mul_lo_next;
               step <= step + CW'(1);
               if (step == LAST_STEP) begin
                  acc_q    <= mul_lo_next;
                  acc_hi_q <= mul_hi_next;
                  zero_q   <= ({mul_hi_next, mul_lo_next} == '0);
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state    <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_acc_n.sv
// Directed bench for alu_acc_n at WIDTH = 8 with hand-computed expected values
// covering reset, arithmetic/logic ops, multiply and the boundary cases.
module tb_alu_acc_n;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   alu_acc_n_if #(.WIDTH(8)) bus ();

   alu_acc_n #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic apply_load(input logic [7:0] value);
      @(negedge clk);
      bus.load = 1'b1;
      bus.din  = value;
      @(posedge clk);
      #1;
      bus.load = 1'b0;
   endtask

   task automatic apply_stimulus(input logic [1:0] m, input logic [3:0] sel,
                                 input logic ci_n, input logic [7:0] bv);
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = m;
      bus.s     = sel;
      bus.cin_n = ci_n;
      bus.b     = bv;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic check_flags(input string tag, input logic [7:0] e_acc,
                              input logic e_cout_n, input logic e_zero);
      check_output({tag, "_acc"},    32'(bus.acc),    32'(e_acc));
      check_output({tag, "_cout_n"}, 32'(bus.cout_n), 32'(e_cout_n));
      check_output({tag, "_zero"},   32'(bus.zero),   32'(e_zero));
      check_output({tag, "_done"},   32'(bus.done),   32'd1);
      check_output({tag, "_busy"},   32'(bus.busy),   32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_acc"},    32'(bus.acc),    32'h00);
      check_output({tag, "_acc_hi"}, 32'(bus.acc_hi), 32'h00);
      check_output({tag, "_cout_n"}, 32'(bus.cout_n), 32'd1);
      check_output({tag, "_zero"},   32'(bus.zero),   32'd1);
      check_output({tag, "_busy"},   32'(bus.busy),   32'd0);
      check_output({tag, "_done"},   32'(bus.done),   32'd0);
   endtask

   // Counts busy cycles after a multiply start; may inject load/start noise on
   // one chosen cycle and flags any change of acc while busy.
   task automatic wait_mul(input int noise_cycle, input logic [7:0] hold_acc,
                           output int busy_cycles, output int acc_moved);
      busy_cycles = 0;
      acc_moved   = 0;
      while (bus.busy && busy_cycles < 20) begin
         busy_cycles++;
         if (bus.acc !== hold_acc) acc_moved = 1;
         if (busy_cycles == noise_cycle) begin
            bus.load  = 1'b1;
            bus.start = 1'b1;
            bus.din   = 8'h55;
            bus.mode  = 2'b01;
         end else begin
            bus.load  = 1'b0;
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      bus.load  = 1'b0;
      bus.start = 1'b0;
   endtask

   initial begin
      int busy_cycles;
      int acc_moved;
      int done_seen;
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      bus.load  = 1'b0;
      bus.din   = '0;
      bus.start = 1'b0;
      bus.mode  = 2'b00;
      bus.s     = 4'h0;
      bus.cin_n = 1'b1;
      bus.b     = '0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;

      apply_load(8'hF0);
      check_output("load_acc", 32'(bus.acc), 32'hF0);
      check_output("load_zero", 32'(bus.zero), 32'd0);
      check_output("load_done", 32'(bus.done), 32'd0);

      apply_stimulus(2'b01, 4'h9, 1'b1, 8'h20);
      check_flags("add", 8'h10, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_output("add_done_drop", 32'(bus.done), 32'd0);

      apply_stimulus(2'b01, 4'h6, 1'b0, 8'h10);
      check_flags("sub", 8'h00, 1'b0, 1'b1);

      apply_stimulus(2'b00, 4'hF, 1'b1, 8'hAA);
      check_flags("logic_a_keep_cout", 8'h00, 1'b0, 1'b1);

      apply_stimulus(2'b01, 4'hF, 1'b1, 8'h00);
      check_flags("minus_one", 8'hFF, 1'b1, 1'b0);

      apply_stimulus(2'b00, 4'hC, 1'b0, 8'h00);
      check_flags("logic_ones", 8'hFF, 1'b1, 1'b0);

      apply_stimulus(2'b00, 4'h6, 1'b0, 8'hFF);
      check_flags("logic_xor", 8'h00, 1'b1, 1'b1);

      apply_stimulus(2'b01, 4'h3, 1'b0, 8'h00);
      check_flags("neg1_plus_cin", 8'h00, 1'b0, 1'b1);

      apply_load(8'h0C);
      apply_stimulus(2'b01, 4'h4, 1'b1, 8'h0A);
      check_flags("a_plus_a_and_nb", 8'h10, 1'b1, 1'b0);

      apply_stimulus(2'b00, 4'h2, 1'b1, 8'h35);
      check_flags("logic_na_and_b", 8'h25, 1'b1, 1'b0);

      apply_stimulus(2'b11, 4'h9, 1'b0, 8'hFF);
      check_flags("reserved", 8'h25, 1'b1, 1'b0);

      // Back-to-back increments with start held high
      apply_load(8'h7E);
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = 2'b01;
      bus.s     = 4'h0;
      bus.cin_n = 1'b0;
      @(posedge clk);
      #1;
      check_flags("b2b_first", 8'h7F, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check_flags("b2b_second", 8'h80, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check_output("b2b_done_drop", 32'(bus.done), 32'd0);

      apply_load(8'hFF);
      apply_stimulus(2'b10, 4'h0, 1'b1, 8'hFF);
      bus.b = 8'h00;
      check_output("mul_busy_start", 32'(bus.busy), 32'd1);
      check_output("mul_no_early_done", 32'(bus.done), 32'd0);
      wait_mul(3, 8'hFF, busy_cycles, acc_moved);
      check_output("mul_busy_cycles", 32'(busy_cycles), 32'd8);
      check_output("mul_acc_held", 32'(acc_moved), 32'd0);
      check_output("mul_acc", 32'(bus.acc), 32'h01);
      check_output("mul_acc_hi", 32'(bus.acc_hi), 32'hFE);
      check_output("mul_zero", 32'(bus.zero), 32'd0);
      check_output("mul_done", 32'(bus.done), 32'd1);
      check_output("mul_cout_keep", 32'(bus.cout_n), 32'd1);

      // Restart on the edge where done is high: multiply 0x01 by zero
      bus.start = 1'b1;
      bus.mode  = 2'b10;
      bus.b     = 8'h00;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check_output("mul0_accepted", 32'(bus.busy), 32'd1);
      wait_mul(0, 8'h01, busy_cycles, acc_moved);
      check_output("mul0_busy_cycles", 32'(busy_cycles), 32'd8);
      check_output("mul0_acc", 32'(bus.acc), 32'h00);
      check_output("mul0_acc_hi", 32'(bus.acc_hi), 32'h00);
      check_output("mul0_zero", 32'(bus.zero), 32'd1);
      check_output("mul0_done", 32'(bus.done), 32'd1);

      // Reset asserted mid-cycle during the 4th busy cycle
      apply_load(8'h05);
      apply_stimulus(2'b10, 4'h0, 1'b1, 8'h03);
      repeat (3) @(posedge clk);
      #2;
      check_output("rst_mid_busy_before", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_values("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (bus.done) done_seen++;
      end
      check_output("rst_mid_no_done", 32'(done_seen), 32'd0);
      check_output("rst_mid_acc_after", 32'(bus.acc), 32'h00);

      // Load wins over start
      @(negedge clk);
      bus.load  = 1'b1;
      bus.start = 1'b1;
      bus.din   = 8'h3C;
      bus.mode  = 2'b01;
      bus.s     = 4'h9;
      bus.cin_n = 1'b1;
      bus.b     = 8'h01;
      @(posedge clk);
      #1;
      bus.load  = 1'b0;
      bus.start = 1'b0;
      check_output("load_start_acc", 32'(bus.acc), 32'h3C);
      check_output("load_start_done", 32'(bus.done), 32'd0);
      check_output("load_start_zero", 32'(bus.zero), 32'd0);
      @(posedge clk);
      #1;
      check_output("load_start_done_late", 32'(bus.done), 32'd0);
      check_output("load_start_acc_late", 32'(bus.acc), 32'h3C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
